mux_4_to_1: RTL and testbench
=============================

// Module: mux_4_to_1
// PURPOSE
//   Selects one of four data inputs (A, B, C, D) onto output Y using the 2-bit select {S1,S0}.
//   Y is a pure combinational path for datapath steering.
//   Y_q is an optional registered copy for timing-critical consumers.
//   sel_oh is a one-hot select decode for downstream enable logic.
// PARAMETERS
//   WIDTH   1   data width of A, B, C, D, Y, Y_q (>=1)
// PORTS
//   clk     in   1      single clock; all state updates on rising edge
//   rst     in   1      synchronous, active-high reset
//   S0      in   1      select bit 0 (LSB)
//   S1      in   1      select bit 1 (MSB)
//   A       in   WIDTH  data input, chosen when {S1,S0}=2'b00
//   B       in   WIDTH  data input, chosen when {S1,S0}=2'b01
//   C       in   WIDTH  data input, chosen when {S1,S0}=2'b10
//   D       in   WIDTH  data input, chosen when {S1,S0}=2'b11
//   Y       out  WIDTH  combinational mux output
//   Y_q     out  WIDTH  registered mux output (see CONFIGURATION)
//   sel_oh  out  4      one-hot select decode; bit0=A ... bit3=D
// BEHAVIOUR
//   - Y = A|B|C|D per {S1,S0} = 00|01|10|11. Zero latency.
//   - Y does not depend on clk or rst: reset does not force Y.
//   - Y updates in the same delta as any input change.
//   - sel_oh = 4'b0001 << {S1,S0}. Combinational; exactly one bit is set for known selects.
//   - X/Z on S0 or S1: Y and sel_oh are X in simulation. No X-masking logic.
//   - Y_q (macro defined): Y_q <= rst ? '0 : Y on each rising clk.
//     Latency is 1 cycle. Reset value is all-zero. rst has priority over data.
//   - rst asserted mid-stream: Y_q is 0 on the first edge with rst=1.
//     It holds 0 until the first edge with rst=0, then follows Y with 1-cycle latency.
//   - Simultaneous select and data change: Y reflects the new select applied to the new data.
//     No glitch-free guarantee is given.
//   - Width rules: all data paths are WIDTH bits. No extension or truncation.
// CONFIGURATION
//   MUX4_OUT_REG_EN defined:
//     Y_q is a flop stage with the sync reset described above.
//   MUX4_OUT_REG_EN undefined:
//     No flops are inferred. Y_q is driven constant '0. clk and rst are unused.
//   Y and sel_oh are identical in both builds.
// STRUCTURE
//   - Package mux4_pkg holds:
//     localparams SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11
//     typedef logic [1:0] mux4_sel_t
//   - Sub-module mux4_sel_decode: mux4_sel_t in -> 4-bit one-hot out, purely combinational.
//     Its output drives sel_oh.
//   - Data select is an AND-OR of sel_oh with each input, replicated to WIDTH.
//     Optional flop stage sits on top of it.
// TESTING (WIDTH=1, macro defined unless noted)
//   1. All inputs 0, S=00 -> Y=0, sel_oh=0001.
//      Then A=1, S=00 -> Y=1.
//   2. One-hot walk:
//      B=1 others 0, S=01 -> Y=1, sel_oh=0010.
//      C=1, S=10 -> Y=1, sel_oh=0100.
//      D=1, S=11 -> Y=1, sel_oh=1000.
//   3. A=1,B=0,C=1,D=0, sweep S=00,01,10 -> Y=1,0,1.
//      Then A=1,B=0,C=1,D=1, S=11 -> Y=1.
//   4. Registered path: rst=1 for 2 edges -> Y_q=0.
//      Release rst with A=1, S=00 -> Y_q=1 one edge later.
//      Switch to S=01, B=0 -> Y=0 at once, Y_q=0 next edge.
//   5. Reset mid-stream: Y_q=1, assert rst -> Y_q=0 at next edge while Y stays 1.
//      Deassert rst -> Y_q=1 next edge.
//   6. Macro undefined: repeat scenarios 1-3 -> identical Y and sel_oh; Y_q constant 0.

Source files
------------

// File: rtl/mux4_pkg.sv
// rtl/mux4_pkg.sv - select encodings and select type shared by the 4:1 mux slice
package mux4_pkg;

  typedef logic [1:0] mux4_sel_t;

  localparam mux4_sel_t SEL_A = 2'b00;
  localparam mux4_sel_t SEL_B = 2'b01;
  localparam mux4_sel_t SEL_C = 2'b10;
  localparam mux4_sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4_sel_decode.sv
// rtl/mux4_sel_decode.sv - combinational 2-bit select to 4-bit one-hot decode
module mux4_sel_decode
  import mux4_pkg::*;
(
  input  mux4_sel_t  sel,
  output logic [3:0] sel_oh
);

  // A shift keeps X on the select visible on every output bit in simulation.
  assign sel_oh = 4'b0001 << sel;

endmodule

// File: rtl/mux_4_to_1.sv
// rtl/mux_4_to_1.sv - 4:1 AND-OR mux with one-hot decode; MUX4_OUT_REG_EN adds registered Y_q
module mux_4_to_1
  import mux4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             S0,
  input  logic             S1,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Y_q,
  output logic [3:0]       sel_oh
);

  mux4_sel_t sel;

  assign sel = {S1, S0};

  mux4_sel_decode u_sel_decode (
    .sel    (sel),
    .sel_oh (sel_oh)
  );

  assign Y = ({WIDTH{sel_oh[SEL_A]}} & A)
           | ({WIDTH{sel_oh[SEL_B]}} & B)
           | ({WIDTH{sel_oh[SEL_C]}} & C)
           | ({WIDTH{sel_oh[SEL_D]}} & D);

`ifdef MUX4_OUT_REG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      Y_q <= '0;
    end else begin
      Y_q <= Y;
    end
  end
`else
  // Without the output stage the clock and reset have no loads.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign Y_q = '0;
`endif

endmodule

// File: tb/tb_mux_4_to_1.sv
// tb/tb_mux_4_to_1.sv - directed self-checking bench for mux_4_to_1 (Y_q expectations follow MUX4_OUT_REG_EN)
module tb_mux_4_to_1;

`ifdef MUX4_OUT_REG_EN
  localparam bit REG_EN = 1'b1;
`else
  localparam bit REG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       S0, S1;
  logic [0:0] A, B, C, D;
  logic [0:0] Y, Y_q;
  logic [3:0] sel_oh;

  logic [7:0] a8, b8, c8, d8;
  logic [7:0] y8, y_q8;
  logic [3:0] sel_oh8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mux_4_to_1 #(.WIDTH(1)) dut (
    .clk    (clk),
    .rst    (rst),
    .S0     (S0),
    .S1     (S1),
    .A      (A),
    .B      (B),
    .C      (C),
    .D      (D),
    .Y      (Y),
    .Y_q    (Y_q),
    .sel_oh (sel_oh)
  );

  mux_4_to_1 #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .S0     (S0),
    .S1     (S1),
    .A      (a8),
    .B      (b8),
    .C      (c8),
    .D      (d8),
    .Y      (y8),
    .Y_q    (y_q8),
    .sel_oh (sel_oh8)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [1:0] s, input logic a, input logic b, input logic c, input logic d);
    {S1, S0} = s;
    A = a; B = b; C = c; D = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic comb_scenarios(input string pfx);
    set_in(2'b00, 0, 0, 0, 0);
    check_val({pfx, "s1_y_zero"}, 32'(Y), 32'h0);
    check_val({pfx, "s1_oh_a"}, 32'(sel_oh), 32'h1);
    set_in(2'b00, 1, 0, 0, 0);
    check_val({pfx, "s1_y_a"}, 32'(Y), 32'h1);
    set_in(2'b01, 0, 1, 0, 0);
    check_val({pfx, "s2_y_b"}, 32'(Y), 32'h1);
    check_val({pfx, "s2_oh_b"}, 32'(sel_oh), 32'h2);
    set_in(2'b10, 0, 0, 1, 0);
    check_val({pfx, "s2_y_c"}, 32'(Y), 32'h1);
    check_val({pfx, "s2_oh_c"}, 32'(sel_oh), 32'h4);
    set_in(2'b11, 0, 0, 0, 1);
    check_val({pfx, "s2_y_d"}, 32'(Y), 32'h1);
    check_val({pfx, "s2_oh_d"}, 32'(sel_oh), 32'h8);
    set_in(2'b00, 1, 0, 1, 0);
    check_val({pfx, "s3_y_00"}, 32'(Y), 32'h1);
    set_in(2'b01, 1, 0, 1, 0);
    check_val({pfx, "s3_y_01"}, 32'(Y), 32'h0);
    set_in(2'b10, 1, 0, 1, 0);
    check_val({pfx, "s3_y_10"}, 32'(Y), 32'h1);
    set_in(2'b11, 1, 0, 1, 1);
    check_val({pfx, "s3_y_11"}, 32'(Y), 32'h1);
    set_in(2'b11, 1, 1, 1, 0);
    check_val({pfx, "s3_y_11_d0"}, 32'(Y), 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    a8 = 8'hA5; b8 = 8'h3C; c8 = 8'h0F; d8 = 8'hF0;
    set_in(2'b00, 0, 0, 0, 0);

    comb_scenarios("");

    // Registered path: two reset edges, then release.
    rst = 1'b1;
    tick();
    check_val("s4_rst_edge1", 32'(Y_q), 32'h0);
    tick();
    check_val("s4_rst_edge2", 32'(Y_q), 32'h0);
    rst = 1'b0;
    set_in(2'b00, 1, 0, 0, 0);
    tick();
    check_val("s4_yq_a", 32'(Y_q), 32'(REG_EN));
    set_in(2'b01, 1, 0, 0, 0);
    check_val("s4_y_b_now", 32'(Y), 32'h0);
    check_val("s4_yq_hold", 32'(Y_q), 32'(REG_EN));
    tick();
    check_val("s4_yq_b", 32'(Y_q), 32'h0);

    // Reset mid-stream while Y stays high.
    set_in(2'b00, 1, 0, 0, 0);
    tick();
    check_val("s5_yq_pre", 32'(Y_q), 32'(REG_EN));
    rst = 1'b1;
    tick();
    check_val("s5_yq_rst", 32'(Y_q), 32'h0);
    check_val("s5_y_stays", 32'(Y), 32'h1);
    tick();
    check_val("s5_yq_rst_hold", 32'(Y_q), 32'h0);
    rst = 1'b0;
    tick();
    check_val("s5_yq_resume", 32'(Y_q), 32'(REG_EN));

    // Wide instance: full-width steering and registered copy.
    set_in(2'b00, 0, 0, 0, 0);
    check_val("w8_a", 32'(y8), 32'hA5);
    set_in(2'b01, 0, 0, 0, 0);
    check_val("w8_b", 32'(y8), 32'h3C);
    set_in(2'b10, 0, 0, 0, 0);
    check_val("w8_c", 32'(y8), 32'h0F);
    set_in(2'b11, 0, 0, 0, 0);
    check_val("w8_d", 32'(y8), 32'hF0);
    check_val("w8_oh_d", 32'(sel_oh8), 32'h8);
    tick();
    check_val("w8_yq_d", 32'(y_q8), REG_EN ? 32'hF0 : 32'h0);
    d8 = 8'h81;
    #1;
    check_val("w8_d_new", 32'(y8), 32'h81);
    tick();
    check_val("w8_yq_d_new", 32'(y_q8), REG_EN ? 32'h81 : 32'h0);

    // Combinational behaviour must be unaffected by reset.
    rst = 1'b1;
    comb_scenarios("rst_");
    tick();
    check_val("final_yq_rst", 32'(Y_q), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
